pipe_chain: RTL

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pipe_chain.sv
// Valid/allowin pipeline chain with per-stage flush, late result
// update and youngest-first forwarding queries.
module pipe_chain #(
   parameter int NSTG   = 4,
   parameter int PAY_W  = 64,
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int NRD    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_allowin,
   input  logic [PAY_W-1:0]       in_payload,
   input  logic                   in_rf_we,
   input  logic [REG_W-1:0]       in_dest,
   input  logic [DATA_W-1:0]      in_result,
   input  logic                   in_result_ok,
   input  logic [NSTG-1:0]        stg_ready,
   input  logic [NSTG-1:0]        flush,
   input  logic [NSTG-1:0]        upd_valid,
   input  logic [NSTG*DATA_W-1:0] upd_result,
   output logic                   out_valid,
   input  logic                   out_allowin,
   output logic [PAY_W-1:0]       out_payload,
   output logic                   out_rf_we,
   output logic [REG_W-1:0]       out_dest,
   output logic [DATA_W-1:0]      out_result,
   input  logic [NRD*REG_W-1:0]   q_reg,
   output logic [NRD-1:0]         q_hit,
   output logic [NRD-1:0]         q_stall,
   output logic [NRD*DATA_W-1:0]  q_data
);

   logic [NSTG-1:0]   r_valid;
   logic [NSTG-1:0]   r_we;
   logic [NSTG-1:0]   r_ok;
   logic [PAY_W-1:0]  r_pay  [NSTG];
   logic [REG_W-1:0]  r_dest [NSTG];
   logic [DATA_W-1:0] r_res  [NSTG];

   logic [NSTG:0]     w_allow;
   logic [NSTG-1:0]   w_kill;
   logic [NSTG-1:0]   w_send;
   logic [NSTG-1:0]   w_recv;
   logic [NSTG-1:0]   w_upd;
   logic [NSTG-1:0]   w_ok;
   logic [DATA_W-1:0] w_res  [NSTG];
   logic [NSTG-1:0]   w_src_we;
   logic [NSTG-1:0]   w_src_ok;
   logic [PAY_W-1:0]  w_src_pay  [NSTG];
   logic [REG_W-1:0]  w_src_dest [NSTG];
   logic [DATA_W-1:0] w_src_res  [NSTG];

   // Backpressure ripples from the output back; kill covers every stage at or below a flush bit.
   always_comb begin
      logic a;
      logic k;
      a = out_allowin;
      k = 1'b0;
      w_allow = '0;
      w_kill  = '0;
      w_allow[NSTG] = out_allowin;
      for (int i = NSTG-1; i >= 0; i--) begin
         a = !r_valid[i] || (stg_ready[i] && a);
         w_allow[i] = a;
         k = k | flush[i];
         w_kill[i] = k;
      end
   end

   // Late result write merged in front of the registers so a moving item carries it.
   always_comb begin
      w_upd = '0;
      w_ok  = '0;
      for (int i = 0; i < NSTG; i++) begin
         w_upd[i] = upd_valid[i] && r_valid[i];
         w_res[i] = w_upd[i] ? upd_result[i*DATA_W +: DATA_W] : r_res[i];
         w_ok[i]  = r_ok[i] | w_upd[i];
      end
   end

   // Per-stage send/receive; an item leaving a killed stage is not received downstream.
   always_comb begin
      w_send = '0;
      w_recv = '0;
      for (int i = 0; i < NSTG; i++)
         w_send[i] = r_valid[i] && stg_ready[i] && w_allow[i+1];
      w_recv[0] = in_valid && w_allow[0] && !(|flush);
      for (int i = 1; i < NSTG; i++)
         w_recv[i] = w_send[i-1] && !w_kill[i-1];
   end

   // Source of the contents loaded into each stage: upstream input or previous stage.
   always_comb begin
      w_src_we  = '0;
      w_src_ok  = '0;
      w_src_pay[0]  = in_payload;
      w_src_dest[0] = in_dest;
      w_src_res[0]  = in_result;
      w_src_we[0]   = in_rf_we;
      w_src_ok[0]   = in_result_ok;
      for (int i = 1; i < NSTG; i++) begin
         w_src_pay[i]  = r_pay[i-1];
         w_src_dest[i] = r_dest[i-1];
         w_src_res[i]  = w_res[i-1];
         w_src_we[i]   = r_we[i-1];
         w_src_ok[i]   = w_ok[i-1];
      end
   end

   // Stage registers: kill beats load, load beats drain, idle stage absorbs updates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
         r_we    <= '0;
         r_ok    <= '0;
         for (int i = 0; i < NSTG; i++) begin
            r_pay[i]  <= '0;
            r_dest[i] <= '0;
            r_res[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NSTG; i++) begin
            if (w_kill[i]) begin
               r_valid[i] <= 1'b0;
            end else if (w_recv[i]) begin
               r_valid[i] <= 1'b1;
               r_pay[i]   <= w_src_pay[i];
               r_dest[i]  <= w_src_dest[i];
               r_res[i]   <= w_src_res[i];
               r_we[i]    <= w_src_we[i];
               r_ok[i]    <= w_src_ok[i];
            end else begin
               if (w_send[i])
                  r_valid[i] <= 1'b0;
               r_res[i] <= w_res[i];
               r_ok[i]  <= w_ok[i];
            end
         end
      end
   end

   assign in_allowin  = w_allow[0];
   assign out_valid   = r_valid[NSTG-1] && stg_ready[NSTG-1];
   assign out_payload = r_pay[NSTG-1];
   assign out_rf_we   = r_we[NSTG-1];
   assign out_dest    = r_dest[NSTG-1];
   assign out_result  = w_res[NSTG-1];

   // Forwarding lookup; scanning oldest to youngest lets the youngest match win.
   always_comb begin
      logic [REG_W-1:0] qr;
      qr      = '0;
      q_hit   = '0;
      q_stall = '0;
      q_data  = '0;
      for (int n = 0; n < NRD; n++) begin
         qr = q_reg[n*REG_W +: REG_W];
         if (qr != '0) begin
            for (int i = NSTG-1; i >= 0; i--) begin
               if (r_valid[i] && r_we[i] && (r_dest[i] == qr)) begin
                  q_hit[n]   = 1'b1;
                  q_stall[n] = !r_ok[i];
                  q_data[n*DATA_W +: DATA_W] = r_res[i];
               end
            end
         end
      end
   end

endmodule
